// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Synchronizes and debounces the board's mechanical inputs (push-buttons and
// slide switches) for the MSP430 core's P1/P2 `din` buses. Each bit passes
// through a two-flop synchronizer and then a per-bit qualify counter. A bit
// changes state only after it has held a new level for DEBOUNCE_CYCLES
// consecutive cycles.
//
// Parameters:
//   WIDTH           - number of independent input bits
//   DEBOUNCE_CYCLES - qualify time in clk_sys cycles (2 .. 2^24-1)
//   RESET_VAL       - reset value of the synchronizer and of stable_out
//   CNT_W           - per-bit counter width; needs 2^CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk_sys    in   1      system clock
//   reset_n    in   1      asynchronous active-low reset
//   raw_in     in   WIDTH  asynchronous raw pin levels
//   stable_out out  WIDTH  debounced levels
//   rise_pulse out  WIDTH  one-cycle pulse when a bit of stable_out goes 0->1
//   fall_pulse out  WIDTH  one-cycle pulse when a bit of stable_out goes 1->0
//   change_any out  1      OR of all rise/fall pulses, registered with them
//   evt_ack    in   WIDTH  clears matching evt_flag bits   (optional)
//   evt_flag   out  WIDTH  sticky per-bit change flags     (optional)
//
// Optional feature macro: INPUT_DEBOUNCER_EVT_LATCH_EN
//   When defined, the evt_ack/evt_flag ports and the sticky flag register are
//   present. When undefined, they are absent.
//
// All outputs are registered. No combinational path runs from input to output.
// -----------------------------------------------------------------------------
module input_debouncer #(
  parameter int unsigned      WIDTH           = 5,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b1}},
  parameter int unsigned      CNT_W           = 24
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             change_any
`ifdef INPUT_DEBOUNCER_EVT_LATCH_EN
  ,
  input  logic [WIDTH-1:0] evt_ack,
  output logic [WIDTH-1:0] evt_flag
`endif
);

  // Terminal count: on the cycle the counter holds this value, a further
  // mismatch completes the qualification.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. The second stage is fed straight from the first,
  // with no logic between the stages.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit qualify FSMs
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stable_d[gi] = stable_q[gi];
      rise_d[gi]   = 1'b0;
      fall_d[gi]   = 1'b0;

      case (state_q)
        ST_STABLE: begin
          if (sync2_q[gi] != stable_q[gi]) begin
            state_d = ST_QUALIFY;
            cnt_d   = CNT_ONE;
          end
        end

        ST_QUALIFY: begin
          if (sync2_q[gi] == stable_q[gi]) begin
            // Level went back before qualifying: treat it as a glitch.
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d      = ST_STABLE;
            cnt_d        = '0;
            stable_d[gi] = sync2_q[gi];
            rise_d[gi]   = sync2_q[gi];
            fall_d[gi]   = ~sync2_q[gi];
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers. The pulses are registered together with the level change,
  // so each pulse is high in exactly the cycle where stable_out shows the new
  // level.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             change_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= RESET_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= |(rise_d | fall_d);
    end
  end

  assign stable_out = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign change_any = change_q;

`ifdef INPUT_DEBOUNCER_EVT_LATCH_EN
  // Sticky event flags. A new event is ORed in after the ack clears, so an event
  // and an ack in the same cycle leave the flag set. The flag rises in the same
  // cycle as the pulse.
  logic [WIDTH-1:0] evt_flag_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      evt_flag_q <= '0;
    end else begin
      evt_flag_q <= (evt_flag_q & ~evt_ack) | rise_d | fall_d;
    end
  end

  assign evt_flag = evt_flag_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Self-checking bench for input_debouncer with WIDTH=5, DEBOUNCE_CYCLES=4 and
// RESET_VAL=5'b11111. Directed scenarios are followed by randomized stimulus.
// Every cycle is compared against a behavioural reference model.
//
// The reference model applies the debounce rule directly. A bit flips at an edge
// when the last DEBOUNCE_CYCLES synchronized samples seen since reset all
// differ from the current stable level.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_input_debouncer;

  localparam int          W   = 5;
  localparam int          D   = 4;
  localparam logic [W-1:0] RV = 5'b11111;

  logic         clk_sys = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] raw_in  = '0;
  logic [W-1:0] stable_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic         change_any;
`ifdef INPUT_DEBOUNCER_EVT_LATCH_EN
  logic [W-1:0] evt_ack = '0;
  logic [W-1:0] evt_flag;
  logic [W-1:0] flag_m;
`endif

  always #5 clk_sys = ~clk_sys;

  input_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .RESET_VAL      (RV),
    .CNT_W          (24)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
    .stable_out(stable_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .change_any(change_any)
`ifdef INPUT_DEBOUNCER_EVT_LATCH_EN
    ,
    .evt_ack   (evt_ack),
    .evt_flag  (evt_flag)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] s1_m, s2_m, stable_m, rise_m, fall_m;
  logic         chg_m;
  logic [W-1:0] hist[$];   // synchronized value seen at each edge since reset

  task automatic model_reset();
    s1_m     = RV;
    s2_m     = RV;
    stable_m = RV;
    rise_m   = '0;
    fall_m   = '0;
    chg_m    = 1'b0;
    hist.delete();
`ifdef INPUT_DEBOUNCER_EVT_LATCH_EN
    flag_m   = '0;
`endif
  endtask

  task automatic model_edge();
    logic [W-1:0] flips;
    int           n;
    bit           all_diff;
    hist.push_back(s2_m);
    if (hist.size() > 16) void'(hist.pop_front());
    n     = hist.size();
    flips = '0;
    for (int b = 0; b < W; b++) begin
      if (n >= D) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (hist[n-1-j][b] == stable_m[b]) all_diff = 1'b0;
        flips[b] = all_diff;
      end
    end
    s2_m     = s1_m;
    s1_m     = raw_in;
    stable_m = stable_m ^ flips;
    rise_m   = flips & stable_m;
    fall_m   = flips & ~stable_m;
    chg_m    = |flips;
`ifdef INPUT_DEBOUNCER_EVT_LATCH_EN
    flag_m   = (flag_m & ~evt_ack) | flips;
`endif
  endtask

  task automatic compare_all();
    check("stable_out", 32'(stable_out), 32'(stable_m));
    check("rise_pulse", 32'(rise_pulse), 32'(rise_m));
    check("fall_pulse", 32'(fall_pulse), 32'(fall_m));
    check("change_any", 32'(change_any), 32'(chg_m));
`ifdef INPUT_DEBOUNCER_EVT_LATCH_EN
    check("evt_flag", 32'(evt_flag), 32'(flag_m));
`endif
  endtask

  // One clock edge: the model follows the DUT, and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk_sys);
    if (!reset_n) model_reset();
    else          model_edge();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset is asserted between edges and checked at once, because it is asynchronous.
  task automatic assert_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
  endtask

  int            seen_at;
  logic [W-1:0]  fall_cap, rise_cap;
  int            pulse_cnt;

  initial begin
    model_reset();

    // Reset values
    raw_in = '0;
    ticks(3);
    check("reset_stable_const", 32'(stable_out), 32'(RV));
    reset_n = 1'b1;
    raw_in  = RV;
    pulse_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (change_any) pulse_cnt++;
    end
    check("idle_no_pulses", 32'(pulse_cnt), 32'd0);
    $display("scenario reset/idle done checks=%0d errors=%0d", checks, errors);

    // Clean press on bit 0. The fall should be visible after the 6th edge (k+5).
    raw_in[0] = 1'b0;
    seen_at   = -1;
    pulse_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (fall_pulse != '0) begin
        seen_at = i;
        pulse_cnt++;
        check("press_fall_vec", 32'(fall_pulse), 32'h01);
      end
    end
    check("press_latency", 32'(seen_at), 32'd6);
    check("press_one_pulse", 32'(pulse_cnt), 32'd1);
    check("press_stable0", 32'(stable_out[0]), 32'd0);
    $display("scenario clean press done checks=%0d errors=%0d", checks, errors);

    // Glitch rejection on bit 1: 3 cycles low is one short of the qualify time.
    raw_in[1] = 1'b0;
    ticks(3);
    raw_in[1] = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (change_any) pulse_cnt++;
    end
    check("glitch_no_pulse", 32'(pulse_cnt), 32'd0);
    check("glitch_stable", 32'(stable_out), 32'h1E);
    $display("scenario glitch done checks=%0d errors=%0d", checks, errors);

    // Simultaneous fall and rise on bits 2..4.
    raw_in[4:2] = 3'b000;
    fall_cap    = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fall_pulse != '0) fall_cap = fall_pulse;
    end
    check("simul_fall_vec", 32'(fall_cap), 32'h1C);
    raw_in[4:2] = 3'b111;
    rise_cap    = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rise_pulse != '0) rise_cap = rise_pulse;
    end
    check("simul_rise_vec", 32'(rise_cap), 32'h1C);
    $display("scenario simultaneous done checks=%0d errors=%0d", checks, errors);

    // Reset in the middle of a qualification.
    raw_in = RV;
    ticks(10);
    raw_in[0] = 1'b0;
    ticks(2);
    assert_reset();
    ticks(2);
    reset_n = 1'b1;
    seen_at = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (fall_pulse[0] && seen_at < 0) seen_at = i;
    end
    check("midrst_fall_latency", 32'(seen_at), 32'd6);
    $display("scenario reset mid-qualify done checks=%0d errors=%0d", checks, errors);

`ifdef INPUT_DEBOUNCER_EVT_LATCH_EN
    // Event latch: a set and an ack in the same cycle leave the flag set.
    raw_in = RV;
    ticks(10);
    evt_ack = RV;
    tick();
    evt_ack = '0;
    raw_in[3] = 1'b0;
    ticks(10);
    check("evt_set", 32'(evt_flag[3]), 32'd1);
    raw_in[3] = 1'b1;
    ticks(5);
    evt_ack[3] = 1'b1;
    tick();
    check("evt_set_wins_pulse", 32'(rise_pulse[3]), 32'd1);
    check("evt_set_wins_flag", 32'(evt_flag[3]), 32'd1);
    evt_ack[3] = 1'b0;
    ticks(3);
    evt_ack[3] = 1'b1;
    tick();
    evt_ack[3] = 1'b0;
    check("evt_solo_ack", 32'(evt_flag[3]), 32'd0);
    $display("scenario event latch done checks=%0d errors=%0d", checks, errors);
`endif

    // Randomized: sparse toggles give a mix of glitches and qualified changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0)
        raw_in[$urandom_range(0, W-1)] ^= 1'b1;
`ifdef INPUT_DEBOUNCER_EVT_LATCH_EN
      evt_ack = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
`endif
      if ($urandom_range(0, 399) == 0) begin
        assert_reset();
        ticks(1);
        reset_n = 1'b1;
      end
      tick();
    end
    $display("scenario random done checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
